// File: rtl/tm1638_spi_rx.sv
// Receive-side model of a TM1638: oversamples the strobe/clock/data bus, assembles
// LSB-first bytes, decodes commands and keeps a shadow of the 16-byte display RAM.
module tm1638_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Stb,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_Dio,
    input  logic [3:0] i_Ram_Addr,
    output logic [7:0] o_Ram_Data,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic       o_Byte_First,
    output logic       o_Frame_Error,
    output logic       o_Display_On,
    output logic [2:0] o_Brightness,
    output logic [3:0] o_Addr,
    output logic       o_Key_Read
);

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_DATA = 2'b01,
        CMD_DISP = 2'b10,
        CMD_ADDR = 2'b11
    } cmd_t;

    logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
    logic [SYNC_STAGES-1:0] live;
    logic                   stb_q, clk_q;
    logic                   stb_s, clk_s, dio_s;
    logic                   stb_rise, stb_fall, clk_rise;

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       byte_done;
    logic       first_byte;
    logic       frame_active;
    logic       armed;
    logic       data_phase;
    logic       mode_fixed;
    logic       mode_read;
    logic [7:0] ram [16];

    assign stb_s    = stb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dio_s    = dio_sync[SYNC_STAGES-1];
    assign stb_rise = ~stb_q & stb_s;
    assign stb_fall = stb_q & ~stb_s;
    assign clk_rise = ~clk_q & clk_s;

    assign o_Ram_Data = ram[i_Ram_Addr];

    // Synchronizers preset to the idle bus; `live` marks stages that hold real pin samples.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            stb_sync <= '1;
            clk_sync <= '1;
            dio_sync <= '0;
            live     <= '0;
            stb_q    <= 1'b1;
            clk_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop in the chain samples its pre-edge neighbour.
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
            live     <= {live[SYNC_STAGES-2:0], 1'b1};
            stb_q    <= stb_s;
            clk_q    <= clk_s;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            byte_done     <= 1'b0;
            first_byte    <= 1'b0;
            frame_active  <= 1'b0;
            armed         <= 1'b0;
            data_phase    <= 1'b0;
            mode_fixed    <= 1'b0;
            mode_read     <= 1'b0;
            o_Byte        <= '0;
            o_Byte_Valid  <= 1'b0;
            o_Byte_First  <= 1'b0;
            o_Frame_Error <= 1'b0;
            o_Display_On  <= 1'b0;
            o_Brightness  <= '0;
            o_Addr        <= '0;
            o_Key_Read    <= 1'b0;
            // NOTE: the RAM shadow must read 0x00 after reset, so it is a reset flop array rather than a RAM macro.
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            o_Byte_Valid  <= 1'b0;
            o_Key_Read    <= 1'b0;
            o_Frame_Error <= 1'b0;
            byte_done     <= 1'b0;
            // A strobe already low when reset lifts must go high once before framing is trusted.
            armed         <= armed | (live[SYNC_STAGES-1] & stb_s);

            if (byte_done) begin
                o_Byte       <= shift_reg;
                o_Byte_Valid <= 1'b1;
                o_Byte_First <= first_byte;
                first_byte   <= 1'b0;
                if (first_byte) begin
                    case (cmd_t'(shift_reg[7:6]))
                        CMD_DATA: begin
                            mode_fixed <= shift_reg[2];
                            mode_read  <= (shift_reg[1:0] == 2'b10);
                            o_Key_Read <= (shift_reg[1:0] == 2'b10);
                            data_phase <= 1'b0;
                        end
                        CMD_ADDR: begin
                            o_Addr     <= shift_reg[3:0];
                            data_phase <= ~mode_read;
                        end
                        CMD_DISP: begin
                            o_Display_On <= shift_reg[3];
                            o_Brightness <= shift_reg[2:0];
                        end
                        default: ;
                    endcase
                end else if (data_phase) begin
                    ram[o_Addr] <= shift_reg;
                    if (!mode_fixed) o_Addr <= o_Addr + 4'd1;
                end
            end

            // Framing comes after decode so a new frame start overrides the per-frame flags.
            if (stb_rise) begin
                if (bit_cnt != 3'd0) o_Frame_Error <= 1'b1;
                bit_cnt      <= '0;
                frame_active <= 1'b0;
            end else if (stb_fall && armed) begin
                frame_active <= 1'b1;
                first_byte   <= 1'b1;
                data_phase   <= 1'b0;
                if (clk_rise) begin
                    shift_reg[0] <= dio_s;
                    bit_cnt      <= 3'd1;
                end else begin
                    bit_cnt <= '0;
                end
            end else if (frame_active && clk_rise && !stb_s) begin
                shift_reg[bit_cnt] <= dio_s;
                bit_cnt            <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tm1638_spi_rx.sv
// Bench for tm1638_spi_rx: directed command frames plus randomized frames checked
// against a frame-level model of the TM1638 command set.
module tb_tm1638_spi_rx;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       stb   = 1'b1;
    logic       sclk  = 1'b1;
    logic       dio   = 1'b0;
    logic [3:0] ram_addr = '0;
    logic [7:0] ram_data, byte_out;
    logic       byte_valid, byte_first, frame_err, disp_on, key_read;
    logic [2:0] bright;
    logic [3:0] addr;

    tm1638_spi_rx #(.SYNC_STAGES(2)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_SPI_Stb    (stb),
        .i_SPI_Clk    (sclk),
        .i_SPI_Dio    (dio),
        .i_Ram_Addr   (ram_addr),
        .o_Ram_Data   (ram_data),
        .o_Byte       (byte_out),
        .o_Byte_Valid (byte_valid),
        .o_Byte_First (byte_first),
        .o_Frame_Error(frame_err),
        .o_Display_On (disp_on),
        .o_Brightness (bright),
        .o_Addr       (addr),
        .o_Key_Read   (key_read)
    );

    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    // Frame-level reference model
    logic [7:0] m_ram [16];
    logic [3:0] m_ptr;
    logic       m_fixed, m_read, m_on;
    logic [2:0] m_bright;
    int         m_keys;
    logic [7:0] exp_byte [$];
    bit         exp_first [$];

    // Observed traffic
    logic [7:0] obs_byte [$];
    bit         obs_first [$];
    int         n_ferr, n_key, n_key_bad, n_long, n_pulse;
    logic       prev_valid = 1'b0, prev_ferr = 1'b0;

    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            if (byte_valid) begin
                obs_byte.push_back(byte_out);
                obs_first.push_back(byte_first);
            end
            if ((byte_valid && prev_valid) || (frame_err && prev_ferr)) n_long++;
            if (frame_err) n_ferr++;
            if (key_read) begin
                n_key++;
                if (!(byte_valid && byte_first)) n_key_bad++;
            end
            if (byte_valid || frame_err || key_read) n_pulse++;
        end
        prev_valid = byte_valid;
        prev_ferr  = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_byte.delete();
        obs_first.delete();
        exp_byte.delete();
        exp_first.delete();
        n_ferr = 0; n_key = 0; n_key_bad = 0; n_long = 0; n_pulse = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_ptr = '0; m_fixed = 0; m_read = 0; m_on = 0; m_bright = '0; m_keys = 0;
    endtask

    task automatic model_frame(input logic [7:0] fb[$]);
        logic [7:0] c;
        c = fb[0];
        for (int i = 0; i < fb.size(); i++) begin
            exp_byte.push_back(fb[i]);
            exp_first.push_back(i == 0);
        end
        case (c[7:6])
            2'b01: begin
                m_fixed = c[2];
                m_read  = (c[1:0] == 2'b10);
                if (m_read) m_keys++;
            end
            2'b11: begin
                m_ptr = c[3:0];
                if (!m_read)
                    for (int i = 1; i < fb.size(); i++) begin
                        m_ram[m_ptr] = fb[i];
                        if (!m_fixed) m_ptr = m_ptr + 4'd1;
                    end
            end
            2'b10: begin
                m_on     = c[3];
                m_bright = c[2:0];
            end
            default: ;
        endcase
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            dio  = b[i];
            tick($urandom_range(2, 4));
            sclk = 1'b1;
            tick($urandom_range(2, 4));
        end
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input int gap);
        stb = 1'b0;
        tick($urandom_range(2, 4));
        for (int i = 0; i < fb.size(); i++) send_bits(fb[i], 8);
        tick(2);
        stb = 1'b1;
        tick(gap);
        model_frame(fb);
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        tick(5);
        checks++;
        if ({byte_out, byte_valid, byte_first, frame_err, disp_on, bright, addr, key_read} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {byte_out, byte_valid, byte_first, frame_err, disp_on, bright, addr, key_read});
        end
        i_Rst = 1'b0;
        model_reset();
        clear_obs();
        tick(100);
        checks++;
        if (n_pulse != 0) begin
            errors++;
            $display("FAIL reset_idle_pulses: got %0d expected 0", n_pulse);
        end
        for (int a = 0; a < 16; a++) begin
            ram_addr = 4'(a);
            #1;
            checks++;
            if (ram_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_ram[%0d]: got %0h expected 00", a, ram_data);
            end
        end
    endtask

    task automatic test_auto_write();
        logic [7:0] q[$];
        clear_obs();
        q = '{8'h40};
        send_frame(q, 6);
        q = '{8'hC0, 8'h3F, 8'h06, 8'h5B};
        send_frame(q, 6);
        tick(6);
        checks++;
        if (obs_byte.size() != 5 || obs_first.size() != 5) begin
            errors++;
            $display("FAIL auto_valid_count: got %0d expected 5", obs_byte.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_byte[i] !== exp_byte[i] || obs_first[i] !== exp_first[i]) begin
                    errors++;
                    $display("FAIL auto_byte[%0d]: got %0h/%0b expected %0h/%0b",
                             i, obs_byte[i], obs_first[i], exp_byte[i], exp_first[i]);
                end
            end
        end
        for (int a = 0; a < 3; a++) begin
            ram_addr = 4'(a);
            #1;
            checks++;
            if (ram_data !== m_ram[a]) begin
                errors++;
                $display("FAIL auto_ram[%0d]: got %0h expected %0h", a, ram_data, m_ram[a]);
            end
        end
        checks++;
        if (addr !== 4'd3) begin
            errors++;
            $display("FAIL auto_addr: got %0d expected 3", addr);
        end
    endtask

    task automatic test_fixed_write();
        logic [7:0] q[$];
        logic [7:0] before6;
        before6 = m_ram[6];
        q = '{8'h44};
        send_frame(q, 6);
        q = '{8'hC5, 8'h11, 8'h22};
        send_frame(q, 6);
        tick(6);
        ram_addr = 4'd5;
        #1;
        checks++;
        if (ram_data !== 8'h22) begin
            errors++;
            $display("FAIL fixed_ram5: got %0h expected 22", ram_data);
        end
        ram_addr = 4'd6;
        #1;
        checks++;
        if (ram_data !== before6) begin
            errors++;
            $display("FAIL fixed_ram6: got %0h expected %0h", ram_data, before6);
        end
        checks++;
        if (addr !== 4'd5) begin
            errors++;
            $display("FAIL fixed_addr: got %0d expected 5", addr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        q = '{8'h40};
        send_frame(q, 6);
        q = '{8'hCF, 8'hAA, 8'hBB};
        send_frame(q, 6);
        tick(6);
        ram_addr = 4'd15;
        #1;
        checks++;
        if (ram_data !== 8'hAA) begin
            errors++;
            $display("FAIL wrap_ram15: got %0h expected AA", ram_data);
        end
        ram_addr = 4'd0;
        #1;
        checks++;
        if (ram_data !== 8'hBB) begin
            errors++;
            $display("FAIL wrap_ram0: got %0h expected BB", ram_data);
        end
        checks++;
        if (addr !== 4'd1) begin
            errors++;
            $display("FAIL wrap_addr: got %0d expected 1", addr);
        end
    endtask

    task automatic test_display_keys();
        logic [7:0] q[$];
        q = '{8'h8C};
        send_frame(q, 6);
        tick(6);
        checks++;
        if (disp_on !== 1'b1 || bright !== 3'd4) begin
            errors++;
            $display("FAIL display_ctrl: got on=%0b br=%0d expected on=1 br=4", disp_on, bright);
        end
        clear_obs();
        q = '{8'h42};
        send_frame(q, 6);
        tick(6);
        checks++;
        if (n_key != 1 || n_key_bad != 0) begin
            errors++;
            $display("FAIL key_read_pulse: got %0d (misaligned %0d) expected 1 (0)", n_key, n_key_bad);
        end
        checks++;
        if (obs_first.size() != 1 || obs_first[0] !== 1'b1) begin
            errors++;
            $display("FAIL key_read_first: got %0d bytes expected 1 first-flagged", obs_first.size());
        end
        for (int a = 0; a < 16; a++) begin
            ram_addr = 4'(a);
            #1;
            checks++;
            if (ram_data !== m_ram[a]) begin
                errors++;
                $display("FAIL key_ram[%0d]: got %0h expected %0h", a, ram_data, m_ram[a]);
            end
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] q[$];
        clear_obs();
        stb = 1'b0;
        tick(3);
        send_bits(8'hC3, 5);
        stb = 1'b1;
        tick(10);
        checks++;
        if (n_ferr != 1 || n_long != 0) begin
            errors++;
            $display("FAIL frame_error_pulse: got %0d (long %0d) expected 1 (0)", n_ferr, n_long);
        end
        checks++;
        if (obs_byte.size() != 0) begin
            errors++;
            $display("FAIL frame_error_no_valid: got %0d expected 0", obs_byte.size());
        end
        q = '{8'h88};
        send_frame(q, 6);
        tick(6);
        checks++;
        if (disp_on !== 1'b1 || bright !== 3'd0) begin
            errors++;
            $display("FAIL after_error_ctrl: got on=%0b br=%0d expected on=1 br=0", disp_on, bright);
        end
        checks++;
        if (obs_byte.size() != 1 || obs_byte[0] !== 8'h88 || n_ferr != 1) begin
            errors++;
            $display("FAIL after_error_byte: got %0d bytes, %0d errors expected 1, 1",
                     obs_byte.size(), n_ferr);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] q[$];
        stb = 1'b0;
        tick(3);
        send_bits(8'h8F, 3);
        i_Rst = 1'b1;
        tick(3);
        i_Rst = 1'b0;
        model_reset();
        clear_obs();
        send_bits(8'h8F, 8);
        tick(2);
        stb = 1'b1;
        tick(8);
        sclk = 1'b1;
        send_bits(8'h8B, 8);
        tick(8);
        checks++;
        if (n_pulse != 0 || disp_on !== 1'b0) begin
            errors++;
            $display("FAIL ignored_frame: got %0d pulses on=%0b expected 0 pulses on=0", n_pulse, disp_on);
        end
        q = '{8'h8A};
        send_frame(q, 6);
        tick(6);
        checks++;
        if (disp_on !== 1'b1 || bright !== 3'd2) begin
            errors++;
            $display("FAIL post_reset_ctrl: got on=%0b br=%0d expected on=1 br=2", disp_on, bright);
        end
    endtask

    task automatic run_random_frames(input string tag, input int count, input int min_gap, input int max_gap);
        logic [7:0] q[$];
        int         k, nd;
        clear_obs();
        m_keys = 0;
        q = '{8'h40};
        send_frame(q, min_gap);
        for (int f = 0; f < count; f++) begin
            k = $urandom_range(0, 9);
            q.delete();
            if (k < 3)       q.push_back({5'b01000, 1'($urandom_range(0, 1)), 2'b00});
            else if (k < 7)  q.push_back({4'b1100, 4'($urandom)});
            else if (k == 7) q.push_back({4'b1000, 4'($urandom)});
            else if (k == 8) q.push_back({2'b01, 6'($urandom)});
            else             q.push_back({2'b00, 6'($urandom)});
            nd = (k < 3) ? 0 : $urandom_range(0, 4);
            for (int d = 0; d < nd; d++) q.push_back(8'($urandom));
            send_frame(q, $urandom_range(min_gap, max_gap));
        end
        tick(8);
        checks++;
        if (obs_byte.size() != exp_byte.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d expected %0d", tag, obs_byte.size(), exp_byte.size());
        end else begin
            for (int i = 0; i < exp_byte.size(); i++) begin
                checks++;
                if (obs_byte[i] !== exp_byte[i] || obs_first[i] !== exp_first[i]) begin
                    errors++;
                    $display("FAIL %s_byte[%0d]: got %0h/%0b expected %0h/%0b",
                             tag, i, obs_byte[i], obs_first[i], exp_byte[i], exp_first[i]);
                end
            end
        end
        for (int a = 0; a < 16; a++) begin
            ram_addr = 4'(a);
            #1;
            checks++;
            if (ram_data !== m_ram[a]) begin
                errors++;
                $display("FAIL %s_ram[%0d]: got %0h expected %0h", tag, a, ram_data, m_ram[a]);
            end
        end
        checks++;
        if (addr !== m_ptr || disp_on !== m_on || bright !== m_bright) begin
            errors++;
            $display("FAIL %s_state: got addr=%0d on=%0b br=%0d expected addr=%0d on=%0b br=%0d",
                     tag, addr, disp_on, bright, m_ptr, m_on, m_bright);
        end
        checks++;
        if (n_key != m_keys || n_key_bad != 0 || n_long != 0 || n_ferr != 0) begin
            errors++;
            $display("FAIL %s_pulses: got keys=%0d bad=%0d long=%0d ferr=%0d expected keys=%0d others 0",
                     tag, n_key, n_key_bad, n_long, n_ferr, m_keys);
        end
    endtask

    task automatic test_random();
        run_random_frames("random", 30, 4, 8);
    endtask

    task automatic test_back_to_back();
        run_random_frames("b2b", 10, 2, 2);
    endtask

    initial begin
        test_reset();
        test_auto_write();
        test_fixed_write();
        test_wrap();
        test_display_keys();
        test_frame_error();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
